// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a 2-entry
// {pc, data} FIFO towards decode, with redirect flush and stale-response
// dropping.
module ifu #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            pc_wr_en_i,
  input  logic [XLEN-1:0] pc_wr_addr_i,
  output logic            iram_req_o,
  output logic [XLEN-1:0] iram_addr_o,
  input  logic            iram_gnt_i,
  input  logic            iram_rvalid_i,
  input  logic [XLEN-1:0] iram_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_data_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] w_req_pc_nxt;
  logic            r_drop;
  logic            w_drop_nxt;

  logic [XLEN-1:0] r_fifo_pc   [0:1];
  logic [XLEN-1:0] r_fifo_data [0:1];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_cnt;

  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [1:0]      w_cnt_after_pop;
  logic [1:0]      w_cnt_nxt;
  logic [XLEN-1:0] w_redirect_pc;

  // A redirect cancels the pop as well as the push: the whole FIFO is flushed.
  assign w_valid         = (r_cnt != 2'd0);
  assign w_pop           = w_valid & inst_ready_i & ~pc_wr_en_i;
  assign w_push          = (r_state == S_WAIT) & iram_rvalid_i & ~r_drop & ~pc_wr_en_i;
  assign w_cnt_after_pop = r_cnt - {1'b0, w_pop};
  assign w_cnt_nxt       = w_cnt_after_pop + {1'b0, w_push};
  assign w_redirect_pc   = pc_wr_addr_i & ALIGN_MASK;

  assign iram_req_o   = (r_state == S_REQ);
  assign iram_addr_o  = r_pc & ALIGN_MASK;
  assign inst_valid_o = w_valid;
  assign inst_data_o  = w_valid ? r_fifo_data[r_rptr] : '0;
  assign inst_pc_o    = w_valid ? r_fifo_pc[r_rptr]   : '0;

  // Next-state, fetch PC and drop-flag decisions; redirect overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_drop_nxt   = r_drop;
    if (pc_wr_en_i) begin
      w_pc_nxt = w_redirect_pc;
      unique case (r_state)
        S_REQ: begin
          // A grant in the redirect cycle leaves a response in flight that
          // belongs to the old path; wait for it and throw it away.
          if (iram_gnt_i) begin
            w_state_nxt = S_WAIT;
            w_drop_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
        S_WAIT: begin
          if (iram_rvalid_i) begin
            w_state_nxt = S_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_WAIT;
            w_drop_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_REQ;
          w_drop_nxt  = 1'b0;
        end
      endcase
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_cnt_after_pop < 2'd2) begin
            w_state_nxt = S_REQ;
          end
        end
        S_REQ: begin
          if (iram_gnt_i) begin
            w_req_pc_nxt = r_pc & ALIGN_MASK;
            w_pc_nxt     = r_pc + PC_STEP;
            w_state_nxt  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (iram_rvalid_i) begin
            if (r_drop) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = S_REQ;
            end else if (w_cnt_nxt < 2'd2) begin
              w_state_nxt = S_REQ;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // FSM, fetch PC, outstanding-request PC and drop flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  // Two-entry instruction FIFO; flushed by redirect.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_data[i] <= '0;
      end
    end else if (pc_wr_en_i) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wptr]   <= r_req_pc;
        r_fifo_data[r_wptr] <= iram_rdata_i;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: randomized memory/consumer/redirect stimulus,
// reference stream model in a queue, monitor comparing every consumed
// instruction plus protocol properties of the memory interface.
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i;
  logic        rst_n_i;
  logic        pc_wr_en_i;
  logic [31:0] pc_wr_addr_i;
  logic        iram_req_o;
  logic [31:0] iram_addr_o;
  logic        iram_gnt_i;
  logic        iram_rvalid_i;
  logic [31:0] iram_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_data_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  ifu #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .pc_wr_en_i    (pc_wr_en_i),
    .pc_wr_addr_i  (pc_wr_addr_i),
    .iram_req_o    (iram_req_o),
    .iram_addr_o   (iram_addr_o),
    .iram_gnt_i    (iram_gnt_i),
    .iram_rvalid_i (iram_rvalid_i),
    .iram_rdata_i  (iram_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_data_o   (inst_data_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  int vectors    = 0;
  int miscompares = 0;

  // Reference: the decode side must see an unbroken word-aligned sequence
  // starting at the last reset/redirect target, each word carrying mem_word(pc).
  ent_t        exp_q[$];
  logic [31:0] model_pc;

  // Memory model state.
  bit          mem_pending = 1'b0;
  bit          mem_stale   = 1'b0;
  logic [31:0] mem_addr    = '0;
  int          mem_cnt     = 0;
  int          gnt_pct     = 100;
  int          dmin        = 1;
  int          dmax        = 1;
  bit          cur_rv_good = 1'b0;
  int          pops        = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: model_pc, data: mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] start);
    exp_q.delete();
    model_pc = start & 32'hFFFF_FFFC;
    topup();
  endtask

  // One clock cycle of stimulus: memory responder, consumer, redirect, reset.
  task automatic cycle(input bit rst, input bit redir_in, input logic [31:0] tgt,
                       input bit rdy, input bit rv_pop_redir, output bit fired);
    bit was_pending;
    bit rv_stale;
    bit redir;
    @(posedge clk_i);
    #1;
    was_pending   = mem_pending;
    rv_stale      = 1'b0;
    redir         = redir_in;
    rst_n_i       = rst;
    inst_ready_i  = rdy;
    iram_gnt_i    = 1'b0;
    iram_rvalid_i = 1'b0;
    iram_rdata_i  = $urandom;
    if (mem_pending) begin
      if (mem_cnt == 0) begin
        iram_rvalid_i = 1'b1;
        iram_rdata_i  = mem_word(mem_addr);
        rv_stale      = mem_stale;
        mem_pending   = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (rv_pop_redir && iram_rvalid_i && inst_valid_o && rdy) redir = 1'b1;
    if (rst && iram_req_o) begin
      check("one_outstanding", 64'(was_pending), 64'd0);
      if (!was_pending && $urandom_range(99) < gnt_pct) begin
        iram_gnt_i  = 1'b1;
        mem_pending = 1'b1;
        mem_addr    = iram_addr_o;
        mem_cnt     = int'($urandom_range(dmax, dmin)) - 1;
        mem_stale   = 1'b0;
      end
    end
    if (!rst) begin
      redir     = 1'b0;
      mem_stale = 1'b1;
      rv_stale  = 1'b1;
      model_restart(RESET_PC);
    end
    if (redir) begin
      mem_stale = 1'b1;
      rv_stale  = 1'b1;
      model_restart(tgt);
    end
    fired        = redir;
    pc_wr_en_i   = redir;
    pc_wr_addr_i = redir ? tgt : $urandom;
    cur_rv_good  = iram_rvalid_i && !rv_stale;
  endtask

  task automatic run(input int n, input bit rdy);
    bit f;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, rdy, 1'b0, f);
  endtask

  // Monitor: consumes DUT output against the model and checks interface rules.
  bit          prev_redir    = 1'b0;
  bit          prev_rv_good  = 1'b0;
  bit          prev_req_hold = 1'b0;
  logic [31:0] prev_addr     = '0;
  bit          redir_chk     = 1'b0;
  logic [31:0] redir_exp     = '0;
  bit          seq_chk       = 1'b0;
  logic [31:0] seq_exp       = '0;
  int          stall         = 0;

  always @(negedge clk_i) begin : monitor
    ent_t e;
    if (!rst_n_i) begin
      prev_redir    = 1'b0;
      prev_rv_good  = 1'b0;
      prev_req_hold = 1'b0;
      redir_chk     = 1'b0;
      seq_chk       = 1'b0;
      stall         = 0;
    end else begin
      if (prev_redir)    check("valid_after_redirect", 64'(inst_valid_o), 64'd0);
      if (prev_rv_good)  check("rvalid_to_valid", 64'(inst_valid_o), 64'd1);
      if (prev_req_hold) begin
        check("req_held", 64'(iram_req_o), 64'd1);
        check("addr_held", 64'(iram_addr_o), 64'(prev_addr));
      end
      if (iram_req_o) begin
        check("addr_aligned", 64'(iram_addr_o[1:0]), 64'd0);
        if (redir_chk) begin
          check("first_addr_after_redirect", 64'(iram_addr_o), 64'(redir_exp));
          redir_chk = 1'b0;
        end
        if (seq_chk) begin
          check("next_seq_addr", 64'(iram_addr_o), 64'(seq_exp));
          seq_chk = 1'b0;
        end
      end
      if (inst_valid_o && inst_ready_i && !pc_wr_en_i) begin
        e = exp_q.pop_front();
        check("inst_pc", 64'(inst_pc_o), 64'(e.pc));
        check("inst_data", 64'(inst_data_o), 64'(e.data));
        topup();
        pops++;
        stall = 0;
      end else if (inst_ready_i) begin
        stall++;
        if (stall > 200) begin
          vectors++;
          miscompares++;
          $display("FAIL no_progress: got no instruction in %0d ready cycles, required at least one", stall);
          stall = 0;
        end
      end
      if (pc_wr_en_i) begin
        redir_chk = 1'b1;
        redir_exp = pc_wr_addr_i & 32'hFFFF_FFFC;
        seq_chk   = 1'b0;
      end else if (iram_req_o && iram_gnt_i) begin
        seq_chk = 1'b1;
        seq_exp = iram_addr_o + 32'd4;
      end
      prev_redir    = pc_wr_en_i;
      prev_rv_good  = cur_rv_good;
      prev_req_hold = iram_req_o && !iram_gnt_i && !pc_wr_en_i;
      prev_addr     = iram_addr_o;
    end
  end

  initial begin : stimulus
    bit found;
    bit f;
    int p0;
    logic [31:0] tgt;
    int r;
    rst_n_i       = 1'b0;
    pc_wr_en_i    = 1'b0;
    pc_wr_addr_i  = '0;
    iram_gnt_i    = 1'b0;
    iram_rvalid_i = 1'b0;
    iram_rdata_i  = '0;
    inst_ready_i  = 1'b0;
    model_restart(RESET_PC);

    // Reset, then first cycle idle, request at RESET_PC on the next.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, f);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, f);
    @(negedge clk_i);
    check("reset_req", 64'(iram_req_o), 64'd0);
    check("reset_valid", 64'(inst_valid_o), 64'd0);
    check("reset_data", 64'(inst_data_o), 64'd0);
    check("reset_pc", 64'(inst_pc_o), 64'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, f);
    @(negedge clk_i);
    check("first_req", 64'(iram_req_o), 64'd1);
    check("first_req_addr", 64'(iram_addr_o), 64'(RESET_PC));

    // Streaming: always grant, one-cycle latency, always ready.
    gnt_pct = 100; dmin = 1; dmax = 1;
    p0 = pops;
    run(12, 1'b1);
    @(negedge clk_i);
    check("stream_rate_ok", 64'(pops - p0 >= 5), 64'd1);

    // Back-pressure: FIFO fills to two, fetching stops, head holds.
    run(10, 1'b0);
    @(negedge clk_i);
    check("full_req_low", 64'(iram_req_o), 64'd0);
    check("full_valid", 64'(inst_valid_o), 64'd1);
    check("full_head_pc", 64'(inst_pc_o), 64'(exp_q[0].pc));
    run(10, 1'b1);

    // Redirect while waiting on a slow response; stale data must be dropped.
    dmin = 3; dmax = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, f);
      if (iram_gnt_i) found = 1'b1;
    end
    check("found_grant_for_wait_redirect", 64'(found), 64'd1);
    cycle(1'b1, 1'b1, 32'h0000_0103, 1'b1, 1'b0, f);
    run(20, 1'b1);

    // Redirect landing on the same cycle as a response and a pop.
    dmin = 1; dmax = 1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cycle(1'b1, 1'b0, 32'h0000_2468, 1'($urandom_range(1)), 1'b1, f);
      found = f;
    end
    check("found_rvalid_pop_redirect", 64'(found), 64'd1);
    run(12, 1'b1);

    // Address wrap at the top of the address space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, f);
    run(20, 1'b1);

    // Reset while a request is outstanding; late response must be ignored.
    dmin = 2; dmax = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, f);
      if (iram_gnt_i) found = 1'b1;
    end
    check("found_grant_for_reset", 64'(found), 64'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, f);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, f);
    @(negedge clk_i);
    check("late_rvalid_ignored", 64'(inst_valid_o), 64'd0);
    check("post_reset_idle", 64'(iram_req_o), 64'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, f);
    @(negedge clk_i);
    check("post_reset_req", 64'(iram_req_o), 64'd1);
    check("post_reset_addr", 64'(iram_addr_o), 64'(RESET_PC));
    run(10, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct = int'($urandom_range(100, 30));
        dmin    = 1;
        dmax    = int'($urandom_range(4, 1));
      end
      r = int'($urandom_range(999));
      if (r < 3) begin
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, f);
      end else begin
        tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        cycle(1'b1, r < 35, tgt, $urandom_range(99) < 70, 1'b0, f);
      end
    end
    gnt_pct = 100;
    run(20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data/address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the fetch address after reset.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 Ports SHALL be:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- pc_wr_en_i  in  1  redirect request (taken branch/jump)
- pc_wr_addr_i  in  XLEN  redirect target
- iram_req_o  out  1  instruction memory request
- iram_addr_o  out  XLEN  request address, word aligned
- iram_gnt_i  in  1  request accepted
- iram_rvalid_i  in  1  read data valid
- iram_rdata_i  in  XLEN  read data
- inst_valid_o  out  1  instruction available to decode
- inst_data_o  out  XLEN  instruction word, feeds decode inst_data_i
- inst_pc_o  out  XLEN  address of inst_data_o
- inst_ready_i  in  1  downstream consumes the instruction

Function
REQ-005 The block SHALL hold a fetch PC, a 2-entry instruction FIFO of {pc, data}, a 2-bit occupancy count, a 1-bit drop flag and a 3-state FSM: IDLE, REQ, WAIT.
REQ-006 iram_addr_o SHALL equal the fetch PC with bits [1:0] forced to 0; the fetch PC SHALL load pc_wr_addr_i with bits [1:0] cleared.
REQ-007 iram_req_o SHALL be 1 exactly in state REQ; address SHALL be held stable until iram_gnt_i, except on redirect.
REQ-008 REQ and iram_gnt_i: the FSM SHALL go to WAIT and the fetch PC SHALL advance by 4, wrapping modulo 2^XLEN.
REQ-009 WAIT and iram_rvalid_i with drop flag 0: {request pc, iram_rdata_i} SHALL be pushed; the FSM SHALL go to REQ if occupancy after push and pop is below 2, else IDLE.
REQ-010 IDLE: the FSM SHALL go to REQ in any cycle where occupancy after that cycle's pop is below 2.
REQ-011 At most one request SHALL be outstanding; a request SHALL issue only if occupancy plus outstanding is below 2, so the FIFO never overflows.
REQ-012 inst_valid_o SHALL be 1 when occupancy is nonzero; inst_data_o/inst_pc_o SHALL show the FIFO head; a pop SHALL occur when inst_valid_o and inst_ready_i.
REQ-013 Simultaneous push and pop SHALL leave occupancy unchanged; pop on empty SHALL not occur; data SHALL leave in fetch order.
REQ-014 Earliest timing: iram_rvalid_i in cycle N SHALL give inst_valid_o in cycle N+1.
REQ-015 Redirect (pc_wr_en_i) SHALL take priority over all other events: FIFO flushed (occupancy 0, no pop counted), fetch PC loaded, FSM to REQ next cycle.
REQ-016 Redirect in WAIT without iram_rvalid_i in the same cycle SHALL set the drop flag; the FSM SHALL stay in WAIT until the stale iram_rvalid_i, discard it, clear the flag and go to REQ.
REQ-017 Redirect in WAIT with iram_rvalid_i in the same cycle SHALL discard that data and leave the drop flag 0.
REQ-018 Redirect in REQ with iram_gnt_i in the same cycle SHALL treat the granted request as stale: drop flag set, FSM to WAIT.
REQ-019 Redirect in REQ without grant SHALL keep iram_req_o high and present the new address next cycle.
REQ-020 inst_valid_o SHALL be 0 the cycle after any redirect.

Reset
REQ-021 While rst_n_i is 0 at a clock edge: FSM SHALL go to IDLE, fetch PC to RESET_PC, occupancy 0, drop flag 0. In the following cycle iram_req_o SHALL be 0, inst_valid_o 0, inst_data_o 0 and inst_pc_o 0.
REQ-022 Reset mid-transaction SHALL abandon any outstanding request; a late iram_rvalid_i after reset with no request issued SHALL be ignored.
REQ-023 In the first cycle after rst_n_i returns to 1 the FSM SHALL be in IDLE; it SHALL enter REQ on the next edge.

Verification
REQ-024 Reset release, memory always grants, rvalid one cycle after grant, inst_ready_i=1 -> inst_pc_o sequence 0x0,0x4,0x8 with matching data, no gaps beyond the handshake.
REQ-025 inst_ready_i=0 for 10 cycles -> occupancy stops at 2, iram_req_o 0, head stays 0x0; ready=1 -> fetch resumes in order.
REQ-026 Redirect to 0x0000_0103 while in WAIT -> stale rvalid dropped, next iram_addr_o=0x0000_0100, first inst_pc_o after redirect=0x100.
REQ-027 Redirect in same cycle as rvalid and pop -> data discarded, inst_valid_o=0 next cycle, next request to the target address.
REQ-028 Fetch PC at 0xFFFF_FFFC granted -> next iram_addr_o=0x0000_0000.
REQ-029 rst_n_i=0 during WAIT, then rvalid -> no inst_valid_o, request at RESET_PC within 2 cycles of release.
